// File: rtl/add32_share_arb_pkg.sv
// Shared constants and helpers for the shared 32-bit adder block.
// Holds the datapath width, the default requester count and the id-width helper.
package add32_share_arb_pkg;

  localparam int DATA_W   = 32;
  localparam int NREQ_DEF = 2;

  // Width needed to index n requesters; never narrower than one bit.
  function automatic int id_width(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/add32.sv
// Unsigned 32-bit adder with carry-out from a single 33-bit add.
// Purely combinational, no backpressure.
module add32
  import add32_share_arb_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] sum,
  output logic              carry
);

  assign {carry, sum} = {1'b0, a} + {1'b0, b};

endmodule

// File: rtl/add32_share_arb_rr_arbiter.sv
// One-hot round-robin grant: first valid requester at or above ptr, wrapping to 0.
// Combinational; grant is zero when no request is valid.
module add32_share_arb_rr_arbiter
  import add32_share_arb_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int IDW  = id_width(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  gnt_id
);

  always_comb begin
    int  idx;
    logic found;
    grant  = '0;
    gnt_id = '0;
    found  = 1'b0;
    idx    = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(ptr) + k) % NREQ;
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        gnt_id     = IDW'(idx);
      end
    end
  end

endmodule

// File: rtl/add32_share_arb.sv
// One shared 32-bit adder, round-robin among NREQ requesters; result registered 1 cycle after accept.
// Stalled response (rsp_valid && !rsp_ready) blocks all accepts and freezes priority.
module add32_share_arb
  import add32_share_arb_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int IDW  = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ*DATA_W-1:0] req_a,
  input  logic [NREQ*DATA_W-1:0] req_b,
  output logic [NREQ-1:0]        req_ready,
  output logic                   rsp_valid,
  output logic [IDW-1:0]         rsp_id,
  output logic [DATA_W-1:0]      rsp_sum,
  output logic                   rsp_carry,
  input  logic                   rsp_ready,
  output logic [15:0]            busy_cnt
);

  logic [IDW-1:0]    rr_ptr;
  logic [NREQ-1:0]   grant;
  logic [IDW-1:0]    gnt_id;
  logic              can_load;
  logic              xfer;
  logic [DATA_W-1:0] sel_a;
  logic [DATA_W-1:0] sel_b;
  logic [DATA_W-1:0] add_sum;
  logic              add_carry;

  add32_share_arb_rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_arb (
    .req    (req_valid),
    .ptr    (rr_ptr),
    .grant  (grant),
    .gnt_id (gnt_id)
  );

  assign can_load  = !rsp_valid || rsp_ready;
  // rst_n gate keeps requesters from seeing an accept while the block is held in reset.
  assign req_ready = (rst_n && can_load) ? grant : '0;
  assign xfer      = |req_ready;

  // Grant is one-hot, so an AND-OR mux selects the operands.
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        sel_a = sel_a | req_a[DATA_W*i +: DATA_W];
        sel_b = sel_b | req_b[DATA_W*i +: DATA_W];
      end
    end
  end

  add32 u_add (
    .a     (sel_a),
    .b     (sel_b),
    .sum   (add_sum),
    .carry (add_carry)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_sum   <= '0;
      rsp_carry <= 1'b0;
      rr_ptr    <= '0;
    end else if (xfer) begin
      rsp_valid <= 1'b1;
      rsp_id    <= gnt_id;
      rsp_sum   <= add_sum;
      rsp_carry <= add_carry;
      rr_ptr    <= (gnt_id == IDW'(NREQ-1)) ? '0 : gnt_id + IDW'(1);
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_cnt <= '0;
    end else if (|req_valid && !xfer && busy_cnt != 16'hFFFF) begin
      busy_cnt <= busy_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_add32_share_arb.sv
module tb_add32_share_arb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [63:0] req_a;
  logic [63:0] req_b;
  logic [1:0]  req_ready;
  logic        rsp_valid;
  logic [0:0]  rsp_id;
  logic [31:0] rsp_sum;
  logic        rsp_carry;
  logic        rsp_ready;
  logic [15:0] busy_cnt;

  int n_vec = 0;
  int n_err = 0;

  add32_share_arb #(.NREQ(2), .IDW(1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_sum   (rsp_sum),
    .rsp_carry (rsp_carry),
    .rsp_ready (rsp_ready),
    .busy_cnt  (busy_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  vld;
    logic [31:0] a0, b0, a1, b1;
    logic        rdy;
    logic [1:0]  e_req_ready;
    logic        e_vld;
    logic        e_id;
    logic [31:0] e_sum;
    logic        e_c;
  } vec_t;

  vec_t tbl [9];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] v, input logic [31:0] a0, b0, a1, b1, input logic rr);
    req_valid = v;
    req_a     = {a1, a0};
    req_b     = {b1, b0};
    rsp_ready = rr;
  endtask

  // Entered just after a rising edge; leaves just after the next one.
  task automatic apply(input int n, input vec_t v);
    drive(v.vld, v.a0, v.b0, v.a1, v.b1, v.rdy);
    #1;
    chk($sformatf("v%0d req_ready", n), 64'(req_ready), 64'(v.e_req_ready));
    @(posedge clk);
    #1;
    chk($sformatf("v%0d rsp_valid", n), 64'(rsp_valid), 64'(v.e_vld));
    chk($sformatf("v%0d rsp_id", n),    64'(rsp_id),    64'(v.e_id));
    chk($sformatf("v%0d rsp_sum", n),   64'(rsp_sum),   64'(v.e_sum));
    chk($sformatf("v%0d rsp_carry", n), 64'(rsp_carry), 64'(v.e_c));
  endtask

  initial begin
    logic [15:0] busy0;
    logic [31:0] ea, eb;

    //          vld    a0            b0            a1            b1            rdy  erdy   ev  id  sum           c
    tbl[0] = '{2'b01, 32'h0000_0004, 32'h0040_0000, 32'h0,        32'h0,        1'b1, 2'b01, 1'b1, 1'b0, 32'h0040_0004, 1'b0};
    tbl[1] = '{2'b01, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0,        32'h0,        1'b1, 2'b01, 1'b1, 1'b0, 32'h0000_0001, 1'b1};
    tbl[2] = '{2'b00, 32'h0,         32'h0,         32'h0,        32'h0,        1'b1, 2'b00, 1'b0, 1'b0, 32'h0000_0001, 1'b1};
    tbl[3] = '{2'b10, 32'h0,         32'h0,         32'h5,        32'h7,        1'b1, 2'b10, 1'b1, 1'b1, 32'h0000_000C, 1'b0};
    tbl[4] = '{2'b10, 32'h0,         32'h0,         32'h8000_0000, 32'h8000_0000, 1'b1, 2'b10, 1'b1, 1'b1, 32'h0000_0000, 1'b1};
    // Back-pressure: response from the round-robin phase (id 1, 0x205+5) must hold.
    tbl[5] = '{2'b11, 32'h10,        32'h20,        32'h40,       32'h80,       1'b0, 2'b00, 1'b1, 1'b1, 32'h0000_020A, 1'b0};
    tbl[6] = '{2'b11, 32'h10,        32'h20,        32'h40,       32'h80,       1'b0, 2'b00, 1'b1, 1'b1, 32'h0000_020A, 1'b0};
    tbl[7] = '{2'b11, 32'h10,        32'h20,        32'h40,       32'h80,       1'b0, 2'b00, 1'b1, 1'b1, 32'h0000_020A, 1'b0};
    // Release: requester 0 follows last-served 1, accepted in the same cycle.
    tbl[8] = '{2'b11, 32'h10,        32'h20,        32'h40,       32'h80,       1'b1, 2'b01, 1'b1, 1'b0, 32'h0000_0030, 1'b0};

    rst_n = 1'b0;
    drive(2'b11, 32'h1, 32'h2, 32'h3, 32'h4, 1'b1);
    #1;
    chk("reset req_ready", 64'(req_ready), 64'h0);
    chk("reset rsp_valid", 64'(rsp_valid), 64'h0);
    chk("reset rsp_id",    64'(rsp_id),    64'h0);
    chk("reset rsp_sum",   64'(rsp_sum),   64'h0);
    chk("reset rsp_carry", 64'(rsp_carry), 64'h0);
    chk("reset busy_cnt",  64'(busy_cnt),  64'h0);
    drive(2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1);
    #11 rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int n = 0; n < 5; n++) apply(n, tbl[n]);
    chk("busy after table head", 64'(busy_cnt), 64'h0);

    // Both requesters continuously valid: strict alternation starting at 0.
    for (int k = 0; k < 6; k++) begin
      drive(2'b11, 32'h100 + k, 32'(k), 32'h200 + k, 32'(k), 1'b1);
      #1;
      chk($sformatf("rr%0d req_ready", k), 64'(req_ready), (k % 2 == 0) ? 64'h1 : 64'h2);
      ea = (k % 2 == 0) ? 32'h100 + k : 32'h200 + k;
      eb = 32'(k);
      @(posedge clk);
      #1;
      chk($sformatf("rr%0d rsp_id", k),  64'(rsp_id),  64'(k % 2));
      chk($sformatf("rr%0d rsp_sum", k), 64'(rsp_sum), 64'(ea + eb));
    end
    chk("busy after rr", 64'(busy_cnt), 64'h0);

    busy0 = busy_cnt;
    for (int n = 5; n < 9; n++) apply(n, tbl[n]);
    chk("busy after backpressure", 64'(busy_cnt), 64'(busy0 + 16'd3));

    // Async reset between edges while a response is held; pointer is at 1 here.
    drive(2'b11, 32'h1, 32'h1, 32'h2, 32'h2, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("async rsp_valid", 64'(rsp_valid), 64'h0);
    chk("async rsp_sum",   64'(rsp_sum),   64'h0);
    chk("async busy_cnt",  64'(busy_cnt),  64'h0);
    chk("async req_ready", 64'(req_ready), 64'h0);
    #3 rst_n = 1'b1;
    rsp_ready = 1'b1;
    #1;
    chk("post-reset req_ready", 64'(req_ready), 64'h1);
    @(posedge clk);
    #1;
    chk("post-reset rsp_valid", 64'(rsp_valid), 64'h1);
    chk("post-reset rsp_id",    64'(rsp_id),    64'h0);
    chk("post-reset rsp_sum",   64'(rsp_sum),   64'h2);

    // Stall long enough to saturate the busy counter.
    rsp_ready = 1'b0;
    repeat (65540) @(posedge clk);
    #1;
    chk("busy saturate",       64'(busy_cnt),  64'hFFFF);
    chk("stall rsp_valid",     64'(rsp_valid), 64'h1);
    chk("stall req_ready",     64'(req_ready), 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/add32_share_arb.md
Name: add32_share_arb

Overview:
- Shares one 32-bit adder datapath between NREQ requesters (e.g. PC+4 generation, branch-target calc, EX address add) in the five-stage pipeline.
- Round-robin arbitration over valid/ready request channels; one registered response channel tagged with the requester id.
- Throughput of one add per cycle when the response sink is ready; back-pressure propagates to requesters.

Parameters:
- NREQ, 2, number of requesters (2..8).
- IDW, 1, requester id width; must satisfy 2**IDW >= NREQ.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  NREQ  per-requester request valid.
- req_a  input  NREQ*32  operand A, requester i in bits [32*i+31:32*i].
- req_b  input  NREQ*32  operand B, same packing.
- req_ready  output  NREQ  per-requester accept; at most one bit high per cycle.
- rsp_valid  output  1  response register holds a result.
- rsp_id  output  IDW  index of the requester that produced the result.
- rsp_sum  output  32  a+b modulo 2**32.
- rsp_carry  output  1  carry-out of bit 31.
- rsp_ready  input  1  response sink accepts this cycle.
- busy_cnt  output  16  saturating count of cycles where any req_valid=1 and no request was accepted.

Behaviour:
- Reset (async assert, sync release): rsp_valid=0, rsp_id=0, rsp_sum=0, rsp_carry=0, busy_cnt=0, rr pointer=0. req_ready=0 while rst_n=0.
- can_load = !rsp_valid || rsp_ready, combinational.
- Grant is combinational: the first i with req_valid[i]=1, searching from the rr pointer upward with wrap at NREQ-1 -> 0. req_ready[i] = can_load && grant[i]. Every other bit is 0.
- Handshake: a transfer occurs when req_valid[i] && req_ready[i]. On a transfer edge:
  - rsp_sum <= a_i+b_i, rsp_carry <= carry, rsp_id <= i, rsp_valid <= 1.
  - rr pointer <= (i+1) mod NREQ.
- Latency: exactly 1 cycle from the accept edge to rsp_valid.
- When rsp_valid && rsp_ready and no transfer occurs: rsp_valid <= 0 and the data registers hold their values.
- When rsp_valid && !rsp_ready: all response registers hold, req_ready=0, and the rr pointer holds.
- Simultaneous drain and load (rsp_ready=1 with a new transfer in the same cycle): the new result overwrites the register. No bubble and no loss.
- Requesters must keep req_valid and their operands stable until accepted. The arbiter does not latch operands before accept.
- The rr pointer changes only on a transfer, so an idle pattern never rotates priority.
- busy_cnt increments when |req_valid && !(|req_ready). It saturates at 16'hFFFF.
- Fairness: with all NREQ requesters continuously valid and rsp_ready=1, each requester is served exactly once in every NREQ consecutive cycles.
- Reset asserted mid-operation: the response in flight is discarded, rsp_valid=0 immediately (async), and the pointer returns to 0.
- Arithmetic: unsigned 32-bit wrap. Overflow is visible only through rsp_carry. No signed flag.

Decomposition:
- Shared package: constant DATA_W=32, the default NREQ, and a localparam-derived IDW helper (clog2 function).
- Sub-module rr_arbiter (NREQ-wide one-hot round-robin grant with pointer input). The datapath instantiates the existing add32 for the sum. The carry comes from a 33-bit add in the wrapper, or from add32 extended to 33 bits; that choice is made at implementation, but it must not produce two adders in synthesis.

Test Plan:
- Reset then single request: requester 0 sends a=32'h0000_0004, b=32'h0040_0000 -> req_ready[0]=1 the same cycle; next cycle rsp_valid=1, rsp_id=0, rsp_sum=32'h0040_0004, rsp_carry=0.
- Wrap and carry: a=32'hFFFF_FFFF, b=32'h0000_0002 -> rsp_sum=32'h0000_0001, rsp_carry=1.
- Round-robin, NREQ=2, both valid continuously with rsp_ready=1 for 6 cycles -> accept order 0,1,0,1,0,1; rsp_id follows the same order one cycle later; busy_cnt=0.
- Back-pressure: hold rsp_ready=0 for 3 cycles with a response pending.
  - Required: req_ready=0 throughout, rsp_* stable, and busy_cnt increments by 3.
  - When rsp_ready rises: the next transfer occurs in that same cycle, and the granted requester is the one after the last-served id.
- Simultaneous drain and load: rsp_valid=1, rsp_ready=1, requester 1 valid with a=5, b=7 -> next cycle rsp_valid=1, rsp_id=1, rsp_sum=12, with no idle cycle.
- Async reset mid-stream: assert rst_n=0 between clock edges while rsp_valid=1.
  - Required: rsp_valid=0 without waiting for a clock edge.
  - After release with both requesters valid, requester 0 is granted first.
